// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode encoding, RMW opcode and sequencer state definitions
package alu_pkg;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_EOR = 5'd4;
  localparam logic [4:0] ALU_SR  = 5'd5;
  typedef enum logic [2:0] {OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC} rmw_op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_EX, ST_DW, ST_WR} rmw_state_e;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_DW   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  function automatic logic rmw_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction
endpackage

// File: rtl/rmw_sequencer.sv
// rmw_sequencer: 6502 read-modify-write sequencer driving the shared ALU and memory bus.
// RMW_DUMMY_WRITE_EN adds the cycle-accurate dummy write of the original operand.
module rmw_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        rmw_op,
  input  logic [ADDR_W-1:0] rmw_addr,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [4:0]        alu_mode,
  output logic              alu_cin,
  input  logic [7:0]        alu_out,
  input  logic              alu_cout,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_nz_we,
  output logic              flag_c_we
);
  import alu_pkg::*;
  logic [2:0] state, op;
  logic cin_q, cin_hold;
  logic [7:0] a_hold, b_hold;
  logic [4:0] mode_hold;
  logic [7:0] wr_val;
  logic wr_c, enter_wr;
  wire in_ex = state == S_EX;
  wire dbl = op == OP_ASL || op == OP_ROL;
  wire shr = op == OP_LSR || op == OP_ROR;
  wire rot = op == OP_ROL || op == OP_ROR;
  wire incdec = op == OP_INC || op == OP_DEC;
  // ALU is combinational and shared, so operands are driven only while EX and held otherwise
  assign alu_a = in_ex ? mem_rdata : a_hold;
  assign alu_b = in_ex ? (dbl ? mem_rdata : op == OP_DEC ? 8'h01 : 8'h00) : b_hold;
  assign alu_mode = in_ex ? (shr ? ALU_SR : op == OP_DEC ? ALU_SUB : ALU_ADD) : mode_hold;
  assign alu_cin = in_ex ? (rot ? cin_q : incdec) : cin_hold;
`ifdef RMW_DUMMY_WRITE_EN
  logic [7:0] result;
  logic cout_q;
  localparam logic [2:0] S_AFTER_EX = S_DW;
  assign enter_wr = state == S_DW;
  assign wr_val = result;
  assign wr_c = cout_q;
`else
  localparam logic [2:0] S_AFTER_EX = S_WR;
  assign enter_wr = in_ex;
  assign wr_val = alu_out;
  assign wr_c = alu_cout;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op <= 3'd0;
      cin_q <= 1'b0;
      {busy, done, err, mem_rd, mem_wr, flag_nz_we, flag_c_we} <= '0;
      mem_addr <= '0;
      mem_wdata <= 8'h00;
      {a_hold, b_hold, mode_hold, cin_hold} <= '0;
      {flag_n, flag_z, flag_c} <= '0;
`ifdef RMW_DUMMY_WRITE_EN
      result <= 8'h00;
      cout_q <= 1'b0;
`endif
    end else begin
      {done, err, mem_rd, mem_wr, flag_nz_we, flag_c_we} <= '0;
      {a_hold, b_hold, mode_hold, cin_hold} <= {alu_a, alu_b, alu_mode, alu_cin};
      case (state)
        S_IDLE: if (start) begin
          if (rmw_legal(rmw_op)) begin
            state <= S_RD;
            op <= rmw_op;
            cin_q <= c_in;
            mem_addr <= rmw_addr;
            busy <= 1'b1;
            mem_rd <= 1'b1;
          end else err <= 1'b1;
        end
        S_RD: state <= S_EX;
        S_EX: begin
          state <= S_AFTER_EX;
`ifdef RMW_DUMMY_WRITE_EN
          mem_wr <= 1'b1;
          mem_wdata <= mem_rdata;
          result <= alu_out;
          cout_q <= alu_cout;
`endif
        end
        S_DW: state <= S_WR;
        default: begin
          state <= S_IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
      if (enter_wr) begin
        mem_wr <= 1'b1;
        mem_wdata <= wr_val;
        flag_n <= wr_val[7];
        flag_z <= wr_val == 8'h00;
        flag_nz_we <= 1'b1;
        if (!incdec) begin
          flag_c <= wr_c;
          flag_c_we <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: randomized self-checking bench with a memory, an ALU model and an RMW reference model
module tb_rmw_sequencer;
`ifdef RMW_DUMMY_WRITE_EN
  localparam int LAT = 5;
  localparam int NWR = 2;
`else
  localparam int LAT = 4;
  localparam int NWR = 1;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, c_in = 1'b0;
  logic [2:0] rmw_op = 3'd0;
  logic [15:0] rmw_addr = 16'h0, mem_addr;
  logic busy, done, err, mem_rd, mem_wr, alu_cin, alu_cout;
  logic [7:0] mem_rdata = 8'h00, mem_wdata, alu_a, alu_b, alu_out;
  logic [4:0] alu_mode;
  logic flag_n, flag_z, flag_c, flag_nz_we, flag_c_we;
  logic [7:0] mem [0:65535];
  int errors = 0, checks = 0;

  rmw_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rmw_op(rmw_op), .rmw_addr(rmw_addr), .c_in(c_in),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_nz_we(flag_nz_we), .flag_c_we(flag_c_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // external shared ALU: ADD/SUB with 6502 carry semantics, SR shifts cin into bit 7
  always_comb begin
    logic [8:0] s;
    s = 9'h000;
    case (alu_mode)
      5'd0: s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      5'd1: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
      5'd5: s = {alu_a[0], alu_cin, alu_a[7:1]};
      default: s = 9'h000;
    endcase
    {alu_cout, alu_out} = s;
  end

  // reference: {carry_out, result} for each instruction straight from 6502 semantics
  function automatic logic [8:0] ref_rmw(input logic [2:0] op, input logic [7:0] d, input logic c);
    case (op)
      3'd0: return {d[7], d[6:0], 1'b0};
      3'd1: return {d[0], 1'b0, d[7:1]};
      3'd2: return {d[7], d[6:0], c};
      3'd3: return {d[0], c, d[7:1]};
      3'd4: return {1'b0, d + 8'd1};
      default: return {1'b0, d - 8'd1};
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_rd, mem_wr, flag_nz_we, flag_c_we} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0", {busy, done, err, mem_rd, mem_wr, flag_nz_we, flag_c_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 24'h0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({alu_a, alu_b, alu_mode, alu_cin} !== 22'h0) begin
      errors++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_mode, alu_cin});
    end
    checks++;
    if ({flag_n, flag_z, flag_c} !== 3'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {flag_n, flag_z, flag_c});
    end
    reset = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] d, input logic c, input string tag);
    logic [8:0] e;
    logic [23:0] w[$];
    logic fn, fz, fc, fcwe;
    int busy_n, done_at, rd_n, fl_n;
    e = ref_rmw(op, d, c);
    mem[addr] = d;
    {fn, fz, fc, fcwe} = 4'b0;
    busy_n = 0; done_at = 0; rd_n = 0; fl_n = 0;
    @(negedge clk);
    start = 1'b1; rmw_op = op; rmw_addr = addr; c_in = c;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12 && done_at == 0; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_rd) rd_n++;
      if (mem_wr) w.push_back({mem_addr, mem_wdata});
      if (flag_nz_we) begin fl_n++; {fn, fz, fc, fcwe} = {flag_n, flag_z, flag_c, flag_c_we}; end
      if (done) done_at = i;
    end
    checks++;
    if (done_at != LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, done_at, LAT); end
    checks++;
    if (busy_n != LAT - 1) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, LAT - 1); end
    checks++;
    if (rd_n != 1) begin errors++; $display("FAIL %s reads: got %0d want 1", tag, rd_n); end
    checks++;
    if (w.size() != NWR) begin errors++; $display("FAIL %s writes: got %0d want %0d", tag, w.size(), NWR); end
    if (w.size() > 0) begin
      checks++;
      if (w[0] !== (NWR == 2 ? {addr, d} : {addr, e[7:0]})) begin
        errors++; $display("FAIL %s first_write: got %h want %h", tag, w[0], NWR == 2 ? {addr, d} : {addr, e[7:0]});
      end
      checks++;
      if (w[w.size()-1] !== {addr, e[7:0]}) begin
        errors++; $display("FAIL %s result_write: got %h want %h", tag, w[w.size()-1], {addr, e[7:0]});
      end
    end
    checks++;
    if (fl_n != 1) begin errors++; $display("FAIL %s flag_pulses: got %0d want 1", tag, fl_n); end
    checks++;
    if ({fn, fz, fcwe} !== {e[7], e[7:0] == 8'h00, op < 3'd4}) begin
      errors++; $display("FAIL %s nz_cwe: got %b want %b", tag, {fn, fz, fcwe}, {e[7], e[7:0] == 8'h00, op < 3'd4});
    end
    if (op < 3'd4) begin
      checks++;
      if (fc !== e[8]) begin errors++; $display("FAIL %s carry: got %b want %b", tag, fc, e[8]); end
    end
  endtask

  task automatic test_directed;
    run_op(3'd0, 16'h0010, 8'h81, 1'b0, "asl_81");
    run_op(3'd3, 16'h2000, 8'h01, 1'b1, "ror_01");
    run_op(3'd4, 16'h0300, 8'hFF, 1'b0, "inc_wrap");
    run_op(3'd5, 16'h0301, 8'h00, 1'b1, "dec_wrap");
    run_op(3'd2, 16'hFFFF, 8'h80, 1'b1, "rol_80");
    run_op(3'd1, 16'h0000, 8'h01, 1'b1, "lsr_01");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_illegal;
    for (int k = 6; k <= 7; k++) begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1; rmw_op = 3'(k); rmw_addr = 16'h1234;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if ({err, busy, mem_rd} !== 3'b100) begin
        errors++; $display("FAIL illegal_%0d err_busy_rd: got %b want 100", k, {err, busy, mem_rd});
      end
      repeat (3) begin
        @(negedge clk);
        seen = seen | err | busy | mem_rd | mem_wr | done;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL illegal_%0d quiet: got %b want 0", k, seen); end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] e2;
    logic [23:0] w[$];
    int done_at;
    mem[16'h0040] = 8'h3C;
    mem[16'h0050] = 8'hC3;
    e2 = ref_rmw(3'd3, 8'hC3, 1'b1);
    @(negedge clk);
    start = 1'b1; rmw_op = 3'd0; rmw_addr = 16'h0040; c_in = 1'b0;
    @(posedge clk);
    #1 rmw_op = 3'd3; rmw_addr = 16'h0050; c_in = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 12 && done_at == 0; i++) begin
      @(negedge clk);
      if (mem_wr) w.push_back({mem_addr, mem_wdata});
      if (done) done_at = i;
    end
    checks++;
    if (done_at != LAT || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first_done: got cycle %0d busy %b want cycle %0d busy 0", done_at, busy, LAT);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_rd, mem_addr} !== {2'b11, 16'h0050}) begin
      errors++; $display("FAIL b2b_no_gap: got %h want %h", {busy, mem_rd, mem_addr}, {2'b11, 16'h0050});
    end
    done_at = 0;
    for (int i = 2; i <= 12 && done_at == 0; i++) begin
      @(negedge clk);
      if (mem_wr) w.push_back({mem_addr, mem_wdata});
      if (done) done_at = i;
    end
    checks++;
    if (done_at != LAT) begin errors++; $display("FAIL b2b_second_done: got %0d want %0d", done_at, LAT); end
    checks++;
    if (w.size() != 2 * NWR) begin errors++; $display("FAIL b2b_writes: got %0d want %0d", w.size(), 2 * NWR); end
    else begin
      checks++;
      if ({w[NWR-1], w[2*NWR-1]} !== {16'h0040, 8'h78, 16'h0050, e2[7:0]}) begin
        errors++; $display("FAIL b2b_results: got %h want %h", {w[NWR-1], w[2*NWR-1]}, {16'h0040, 8'h78, 16'h0050, e2[7:0]});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    mem[16'h0077] = 8'h55;
    @(negedge clk);
    start = 1'b1; rmw_op = 3'd0; rmw_addr = 16'h0077; c_in = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1) begin errors++; $display("FAIL midreset_write_in_flight: got %b want 1", mem_wr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({mem_wr, busy, done} !== 3'b000) begin
      errors++; $display("FAIL midreset_abandon: got %b want 000", {mem_wr, busy, done});
    end
    repeat (4) begin
      @(negedge clk);
      seen = seen | done | busy | mem_wr;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_op(3'd4, 16'h0123, 8'h7F, 1'b0, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
